cluster_acc_sync: RTL and testbench

CLUSTER_ACC_SYNC -- requirements
Module: cluster_acc_sync

---
 rtl/ara_pkg.sv | 23 ++
 rtl/cluster_resp_join.sv | 87 ++++++++
 rtl/cluster_acc_sync.sv | 119 +++++++++++
 tb/tb_cluster_acc_sync.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ara_pkg.sv
// ara_pkg -- shared constants and types for the Ara cluster front end.
//
// Contents:
//   MaxNrClusters       upper bound on the number of clusters one CVA6 serves
//   MaxOutstandingLimit upper bound on in-flight requests awaiting a response
//   out_cnt_t           outstanding-count type wide enough for the largest limit
//   F_* / J_*           fork and join FSM state encodings
package ara_pkg;

    localparam int unsigned MaxNrClusters       = 16;
    localparam int unsigned MaxOutstandingLimit = 15;

    typedef logic [$clog2(MaxOutstandingLimit + 1)-1:0] out_cnt_t;

    // Fork FSM: F_PART means some clusters already took the current request.
    localparam logic [0:0] F_IDLE = 1'b0;
    localparam logic [0:0] F_PART = 1'b1;

    // Join FSM: J_EMIT holds the merged response until CVA6 takes it.
    localparam logic [0:0] J_COLLECT = 1'b0;
    localparam logic [0:0] J_EMIT    = 1'b1;

endpackage

// File: rtl/cluster_resp_join.sv
// cluster_resp_join -- merges one response from every cluster into a single
// response towards CVA6.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   cnt_nz_i           at least one request is awaiting a response
//   cl_resp_valid_i    per-cluster response valid
//   cl_resp_exc_i      per-cluster exception flag
//   cl_resp_ready_o    per-cluster response ready
//   resp_valid_o       merged response valid (registered)
//   resp_exc_o         OR of all captured exception flags
//   resp_ready_i       CVA6 response ready
//   err_o              sticky spurious-response flag
module cluster_resp_join
    import ara_pkg::*;
#(
    parameter int unsigned NrClusters = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cnt_nz_i,
    input  logic [NrClusters-1:0] cl_resp_valid_i,
    input  logic [NrClusters-1:0] cl_resp_exc_i,
    output logic [NrClusters-1:0] cl_resp_ready_o,
    output logic                  resp_valid_o,
    output logic                  resp_exc_o,
    input  logic                  resp_ready_i,
    output logic                  err_o
);

    logic [0:0]            state_q, state_d;
    logic [NrClusters-1:0] got_q, got_d;
    logic [NrClusters-1:0] exc_q, exc_d;
    logic                  err_q, err_d;

    logic [NrClusters-1:0] collect_rdy;
    logic [NrClusters-1:0] spurious;
    logic [NrClusters-1:0] resp_hs;

    always_comb begin
        // With nothing outstanding any response is spurious: acknowledge it
        // so the cluster is not stuck, but never record it.
        spurious    = cl_resp_valid_i & {NrClusters{~cnt_nz_i}};
        collect_rdy = (state_q == J_COLLECT) ? (~got_q & {NrClusters{cnt_nz_i}})
                                             : '0;
        cl_resp_ready_o = rst_ni ? (collect_rdy | spurious) : '0;
        resp_hs         = cl_resp_valid_i & collect_rdy;

        state_d = state_q;
        got_d   = got_q;
        exc_d   = exc_q;
        err_d   = err_q | (|spurious);

        if (state_q == J_COLLECT) begin
            got_d = got_q | resp_hs;
            exc_d = exc_q | (resp_hs & cl_resp_exc_i);
            // Include this cycle's handshakes so the merged response is
            // presented exactly one cycle after the last cluster answers.
            if (&got_d) begin
                state_d = J_EMIT;
            end
        end else if (resp_ready_i) begin
            got_d   = '0;
            exc_d   = '0;
            state_d = J_COLLECT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= J_COLLECT;
            got_q   <= '0;
            exc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            got_q   <= got_d;
            exc_q   <= exc_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid_o = (state_q == J_EMIT);
    assign resp_exc_o   = (state_q == J_EMIT) & (|exc_q);
    assign err_o        = err_q;

endmodule

// File: rtl/cluster_acc_sync.sv
// cluster_acc_sync -- forks one CVA6 request to every Ara cluster and joins
// the clusters' responses back into one, bounding in-flight requests.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i        CVA6 request valid
//   req_resp_exp_i     request expects a response (sampled with req_valid_i)
//   req_ready_o        request taken by every cluster
//   cl_req_valid_o     per-cluster request valid
//   cl_req_ready_i     per-cluster request ready
//   cl_resp_valid_i    per-cluster response valid
//   cl_resp_exc_i      per-cluster exception flag
//   cl_resp_ready_o    per-cluster response ready
//   resp_valid_o       merged response valid
//   resp_exc_o         OR of captured exception flags
//   resp_ready_i       CVA6 response ready
//   err_o              sticky spurious-response flag
module cluster_acc_sync
    import ara_pkg::*;
#(
    parameter int unsigned NrClusters     = 4,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic                  req_resp_exp_i,
    output logic                  req_ready_o,
    output logic [NrClusters-1:0] cl_req_valid_o,
    input  logic [NrClusters-1:0] cl_req_ready_i,
    input  logic [NrClusters-1:0] cl_resp_valid_i,
    input  logic [NrClusters-1:0] cl_resp_exc_i,
    output logic [NrClusters-1:0] cl_resp_ready_o,
    output logic                  resp_valid_o,
    output logic                  resp_exc_o,
    input  logic                  resp_ready_i,
    output logic                  err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    if (NrClusters < 1 || NrClusters > MaxNrClusters) begin : g_bad_nr_clusters
        $error("cluster_acc_sync: NrClusters out of range");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > MaxOutstandingLimit) begin : g_bad_max_out
        $error("cluster_acc_sync: MaxOutstanding out of range");
    end

    logic [0:0]            fork_state_q, fork_state_d;
    logic [NrClusters-1:0] acc_q, acc_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic                  credit_ok;
    logic [NrClusters-1:0] taken;
    logic                  req_hs;
    logic                  resp_hs;
    logic                  cnt_inc;
    logic                  cnt_dec;

    // Fork: a cluster that already accepted the current request is masked
    // off so it never sees the same request twice.
    always_comb begin
        taken       = (fork_state_q == F_PART) ? acc_q : '0;
        credit_ok   = (out_cnt_t'(cnt_q) < out_cnt_t'(MaxOutstanding)) | ~req_resp_exp_i;
        req_ready_o = rst_ni & credit_ok & (&(taken | cl_req_ready_i));
        cl_req_valid_o = {NrClusters{rst_ni & req_valid_i & credit_ok}} & ~taken;
        req_hs      = req_valid_i & req_ready_o;

        if (req_hs) begin
            acc_d        = '0;
            fork_state_d = F_IDLE;
        end else begin
            acc_d        = taken | (cl_req_valid_o & cl_req_ready_i);
            fork_state_d = (acc_d != '0) ? F_PART : F_IDLE;
        end
    end

    // Outstanding counter; saturating guards keep it from ever wrapping.
    always_comb begin
        cnt_inc = req_hs & req_resp_exp_i & (cnt_q != CntW'(MaxOutstanding));
        cnt_dec = resp_hs & (cnt_q != '0);
        cnt_d   = cnt_q;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fork_state_q <= F_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
        end else begin
            fork_state_q <= fork_state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
        end
    end

    assign resp_hs = resp_valid_o & resp_ready_i;

    cluster_resp_join #(
        .NrClusters (NrClusters)
    ) i_resp_join (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cnt_nz_i        (cnt_q != '0),
        .cl_resp_valid_i (cl_resp_valid_i),
        .cl_resp_exc_i   (cl_resp_exc_i),
        .cl_resp_ready_o (cl_resp_ready_o),
        .resp_valid_o    (resp_valid_o),
        .resp_exc_o      (resp_exc_o),
        .resp_ready_i    (resp_ready_i),
        .err_o           (err_o)
    );

endmodule

// File: tb/tb_cluster_acc_sync.sv
// Testbench for cluster_acc_sync (NrClusters = 4, MaxOutstanding = 4).
// Inputs change on the falling edge; direct checks sample 1 ns later and the
// response monitor samples 1 ns before the rising edge.
module tb_cluster_acc_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_exp, req_ready;
    logic [3:0] cl_req_valid, cl_req_ready;
    logic [3:0] cl_resp_valid, cl_resp_exc, cl_resp_ready;
    logic       resp_valid, resp_exc, resp_ready, err;

    int vectors     = 0;
    int miscompares = 0;
    bit sb[$];

    always #5 clk = ~clk;

    cluster_acc_sync #(
        .NrClusters     (4),
        .MaxOutstanding (4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_resp_exp_i  (req_exp),
        .req_ready_o     (req_ready),
        .cl_req_valid_o  (cl_req_valid),
        .cl_req_ready_i  (cl_req_ready),
        .cl_resp_valid_i (cl_resp_valid),
        .cl_resp_exc_i   (cl_resp_exc),
        .cl_resp_ready_o (cl_resp_ready),
        .resp_valid_o    (resp_valid),
        .resp_exc_o      (resp_exc),
        .resp_ready_i    (resp_ready),
        .err_o           (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full response round: every cluster answers at once, the merged
    // response appears the next cycle and is taken immediately.
    task automatic resp_round(input logic [3:0] exc);
        @(negedge clk);
        cl_resp_valid = 4'hF;
        cl_resp_exc   = exc;
        sb.push_back(|exc);
        #1 chk("round_cl_resp_ready", cl_resp_ready, 4'hF);
        @(negedge clk);
        cl_resp_valid = 4'h0;
        cl_resp_exc   = 4'h0;
        #1 chk("round_resp_valid", resp_valid, 1'b1);
    endtask

    // Response monitor / scoreboard.
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            #4;
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_resp: got response exc=%0b, expected no response", resp_exc);
                end else begin
                    e = sb.pop_front();
                    chk("resp_exc_sb", resp_exc, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Per-cycle tables for the staggered-response scenario.
    logic [3:0] b_vld[9] = '{4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
    logic [3:0] b_rdy[9] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
    logic       b_rv [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    // Per-cycle tables for the staggered-ready scenario.
    logic [3:0] c_rdy[6] = '{4'h1, 4'h0, 4'h6, 4'h0, 4'h0, 4'h8};
    logic [3:0] c_vld[6] = '{4'hF, 4'hE, 4'hE, 4'h8, 4'h8, 4'h8};
    logic       c_rr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset with live inputs: every output must stay quiet.
        rst_n         = 1'b0;
        req_valid     = 1'b1;
        req_exp       = 1'b1;
        cl_req_ready  = 4'hF;
        cl_resp_valid = 4'hF;
        cl_resp_exc   = 4'hF;
        resp_ready    = 1'b1;
        #2;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_cl_req_valid", cl_req_valid, 4'h0);
        chk("rst_cl_resp_ready", cl_resp_ready, 4'h0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_exc", resp_exc, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        req_valid     = 1'b0;
        cl_req_ready  = 4'h0;
        cl_resp_valid = 4'h0;
        cl_resp_exc   = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        // All clusters ready: accepted in the same cycle.
        @(negedge clk);
        req_valid    = 1'b1;
        req_exp      = 1'b1;
        cl_req_ready = 4'hF;
        #1 chk("a_cl_req_valid", cl_req_valid, 4'hF);
        chk("a_req_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("a_cl_req_valid_after", cl_req_valid, 4'h0);
        chk("a_cnt", dut.cnt_q, 1);

        // Staggered responses, exception only on cluster 2, held emit.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cl_resp_valid = b_vld[i];
            cl_resp_exc   = b_vld[i] & 4'b0100;
            resp_ready    = (i == 7) ? 1'b0 : 1'b1;
            if (i == 7) sb.push_back(1'b1);
            #1 chk($sformatf("b_cl_resp_ready_c%0d", i), cl_resp_ready, b_rdy[i]);
            chk($sformatf("b_resp_valid_c%0d", i), resp_valid, b_rv[i]);
            if (b_rv[i]) chk($sformatf("b_resp_exc_c%0d", i), resp_exc, 1'b1);
        end
        @(negedge clk);
        cl_resp_valid = 4'h0;
        cl_resp_exc   = 4'h0;
        resp_ready    = 1'b1;
        #1 chk("b_cnt", dut.cnt_q, 0);
        chk("b_resp_valid_after", resp_valid, 1'b0);

        // Clusters ready at cycles 0, 2, 2, 5.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid    = 1'b1;
            req_exp      = 1'b1;
            cl_req_ready = c_rdy[i];
            #1 chk($sformatf("c_cl_req_valid_c%0d", i), cl_req_valid, c_vld[i]);
            chk($sformatf("c_req_ready_c%0d", i), req_ready, c_rr[i]);
        end
        @(negedge clk);
        req_valid    = 1'b0;
        cl_req_ready = 4'h0;
        #1 chk("c_cl_req_valid_after", cl_req_valid, 4'h0);
        chk("c_cnt", dut.cnt_q, 1);
        resp_round(4'h0);

        // Reset in the middle of a partial fork.
        @(negedge clk);
        req_valid    = 1'b1;
        req_exp      = 1'b1;
        cl_req_ready = 4'h3;
        #1 chk("d_cl_req_valid_c0", cl_req_valid, 4'hF);
        @(negedge clk);
        cl_req_ready = 4'h0;
        #1 chk("d_cl_req_valid_c1", cl_req_valid, 4'hC);
        @(negedge clk);
        #1 chk("d_cl_req_valid_c2", cl_req_valid, 4'hC);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("d_rst_cl_req_valid", cl_req_valid, 4'h0);
        chk("d_rst_req_ready", req_ready, 1'b0);
        chk("d_rst_resp_valid", resp_valid, 1'b0);
        chk("d_rst_cnt", dut.cnt_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("d_reoffer", cl_req_valid, 4'hF);
        chk("d_req_ready_blocked", req_ready, 1'b0);
        @(negedge clk);
        cl_req_ready = 4'hF;
        #1 chk("d_req_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("d_cnt", dut.cnt_q, 1);
        resp_round(4'b1001);

        // Credit limit.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_exp   = 1'b1;
            #1 chk($sformatf("e_req_ready_%0d", i), req_ready, 1'b1);
        end
        @(negedge clk);
        req_exp = 1'b0;
        #1 chk("e_noexp_req_ready", req_ready, 1'b1);
        @(negedge clk);
        req_exp = 1'b1;
        #1 chk("e_full_req_ready", req_ready, 1'b0);
        chk("e_full_cl_req_valid", cl_req_valid, 4'h0);
        chk("e_full_cnt", dut.cnt_q, 4);
        @(negedge clk);
        #1 chk("e_full_req_ready2", req_ready, 1'b0);
        resp_round(4'b0010);
        @(negedge clk);
        #1 chk("e_freed_cnt", dut.cnt_q, 3);
        chk("e_freed_req_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("e_refill_cnt", dut.cnt_q, 4);
        resp_round(4'h0);
        // Simultaneous request and response handshakes.
        @(negedge clk);
        cl_resp_valid = 4'hF;
        sb.push_back(1'b0);
        #1 chk("e_pre_sim_cnt", dut.cnt_q, 3);
        @(negedge clk);
        cl_resp_valid = 4'h0;
        req_valid     = 1'b1;
        req_exp       = 1'b1;
        #1 chk("e_sim_resp_valid", resp_valid, 1'b1);
        chk("e_sim_req_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("e_sim_cnt", dut.cnt_q, 3);
        for (int i = 0; i < 3; i++) resp_round(4'h0);
        @(negedge clk);
        #1 chk("e_drained_cnt", dut.cnt_q, 0);

        // Spurious response.
        @(negedge clk);
        cl_resp_valid = 4'b0010;
        #1 chk("f_spur_ack", cl_resp_ready, 4'b0010);
        chk("f_err_before", err, 1'b0);
        @(negedge clk);
        cl_resp_valid = 4'h0;
        #1 chk("f_err_set", err, 1'b1);
        chk("f_resp_valid", resp_valid, 1'b0);
        repeat (3) @(negedge clk);
        #1 chk("f_err_sticky", err, 1'b1);
        chk("f_resp_valid_late", resp_valid, 1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
